// File: rtl/change_dispenser.sv
// Coin-return engine: pays a balance out as one-hot coin pulses, largest
// denomination first, within per-denomination stock, and reports what is left unpaid.
module change_dispenser #(
  parameter int kNumCoins   = 3,
  parameter int kTotalBits  = 31,
  parameter int kCoinValue0 = 100,
  parameter int kCoinValue1 = 500,
  parameter int kCoinValue2 = 1000,
  parameter int kInitStock  = 8
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    i_start,
  input  logic [kTotalBits-1:0]   i_amount,
  input  logic                    i_coin_ready,
  input  logic [kNumCoins-1:0]    i_refill,
  output logic [kNumCoins-1:0]    o_return_coin,
  output logic                    o_busy,
  output logic                    o_done,
  output logic [kTotalBits-1:0]   o_remainder,
  output logic [8*kNumCoins-1:0]  o_stock
);

  localparam int kIdxBits = (kNumCoins > 1) ? $clog2(kNumCoins) : 1;

  typedef enum logic [1:0] {
    IDLE     = 2'd0,
    SELECT   = 2'd1,
    DISPENSE = 2'd2,
    DONE     = 2'd3
  } state_t;

  function automatic logic [kTotalBits-1:0] coin_value(input int k);
    case (k)
      0:       return kTotalBits'(kCoinValue0);
      1:       return kTotalBits'(kCoinValue1);
      default: return kTotalBits'(kCoinValue2);
    endcase
  endfunction

  state_t                 state_reg, state_next;
  logic [kTotalBits-1:0]  remaining_reg, remaining_next;
  logic [kTotalBits-1:0]  value_reg, value_next;
  logic [kTotalBits-1:0]  remainder_reg, remainder_next;
  logic [kNumCoins-1:0]   coin_reg, coin_next;

  logic                   sel_found;
  logic [kIdxBits-1:0]    sel_idx;
  logic                   accept;
  logic [kNumCoins-1:0]   dec;

  // Ascending scan so the highest affordable, in-stock denomination wins.
  always_comb begin
    sel_found = 1'b0;
    sel_idx   = '0;
    for (int k = 0; k < kNumCoins; k++) begin
      if (coin_value(k) <= remaining_reg && o_stock[8*k +: 8] != 8'd0) begin
        sel_found = 1'b1;
        sel_idx   = kIdxBits'(k);
      end
    end
  end

  assign accept = (state_reg == DISPENSE) && i_coin_ready;
  assign dec    = accept ? coin_reg : '0;

  always_comb begin
    state_next     = state_reg;
    remaining_next = remaining_reg;
    value_next     = value_reg;
    remainder_next = remainder_reg;
    coin_next      = coin_reg;
    case (state_reg)
      IDLE: begin
        if (i_start) begin
          remaining_next = i_amount;
          remainder_next = '0;
          state_next     = SELECT;
        end
      end
      SELECT: begin
        if (sel_found) begin
          coin_next  = kNumCoins'(1) << sel_idx;
          value_next = coin_value(int'(sel_idx));
          state_next = DISPENSE;
        end else begin
          remainder_next = remaining_reg;
          state_next     = DONE;
        end
      end
      DISPENSE: begin
        if (i_coin_ready) begin
          remaining_next = remaining_reg - value_reg;
          coin_next      = '0;
          state_next     = SELECT;
        end
      end
      DONE: begin
        state_next = IDLE;
      end
      default: begin
        state_next = IDLE;
        coin_next  = '0;
      end
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_reg     <= IDLE;
      remaining_reg <= '0;
      value_reg     <= '0;
      remainder_reg <= '0;
      coin_reg      <= '0;
    end else begin
      state_reg     <= state_next;
      remaining_reg <= remaining_next;
      value_reg     <= value_next;
      remainder_reg <= remainder_next;
      coin_reg      <= coin_next;
    end
  end

  // A refill and a paid coin of the same denomination on one edge cancel out.
  for (genvar gi = 0; gi < kNumCoins; gi++) begin : g_stock
    logic [7:0] count_reg;
    always_ff @(posedge clk or posedge reset) begin
      if (reset) begin
        count_reg <= 8'(kInitStock);
      end else if (dec[gi] && !i_refill[gi]) begin
        count_reg <= count_reg - 8'd1;
      end else if (i_refill[gi] && !dec[gi] && count_reg != 8'hFF) begin
        count_reg <= count_reg + 8'd1;
      end
    end
    assign o_stock[8*gi +: 8] = count_reg;
  end

  assign o_return_coin = coin_reg;
  assign o_busy        = (state_reg != IDLE);
  assign o_done        = (state_reg == DONE);
  assign o_remainder   = remainder_reg;

endmodule

// File: tb/tb_change_dispenser.sv
// Directed bench for change_dispenser: coin order, remainders, stalls, stock
// saturation/collision and asynchronous reset mid-request.
module tb_change_dispenser;

  logic        clk = 1'b0;
  logic        reset;
  logic        i_start;
  logic [30:0] i_amount;
  logic        i_coin_ready;
  logic [2:0]  i_refill;
  logic [2:0]  o_return_coin;
  logic        o_busy;
  logic        o_done;
  logic [30:0] o_remainder;
  logic [23:0] o_stock;

  int n_cmp = 0;
  int n_bad = 0;

  logic [2:0] coin_log [$];
  int         done_cyc;
  logic       timed_out;
  logic [30:0] got_rem;
  logic       busy_after;

  change_dispenser dut (
    .clk(clk), .reset(reset), .i_start(i_start), .i_amount(i_amount),
    .i_coin_ready(i_coin_ready), .i_refill(i_refill),
    .o_return_coin(o_return_coin), .o_busy(o_busy), .o_done(o_done),
    .o_remainder(o_remainder), .o_stock(o_stock)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  // Runs one request with the hopper always ready and logs accepted coins.
  task automatic pay(input logic [30:0] amount);
    int cyc;
    coin_log.delete();
    i_amount     = amount;
    i_coin_ready = 1'b1;
    i_start      = 1'b1;
    step();
    i_start = 1'b0;
    cyc = 0;
    while (!o_done && cyc < 200) begin
      if (o_return_coin != 3'b000) coin_log.push_back(o_return_coin);
      step();
      cyc++;
    end
    timed_out = !o_done;
    done_cyc  = cyc;
    got_rem   = o_remainder;
    step();
    busy_after = o_busy;
    $display("pay amount=%0d coins=%0d done_cycle=%0d remainder=%0d stock=%0d/%0d/%0d",
             amount, coin_log.size(), done_cyc, got_rem,
             o_stock[23:16], o_stock[15:8], o_stock[7:0]);
  endtask

  task automatic check_stock(input string name, input logic [7:0] c2, input logic [7:0] c1,
                             input logic [7:0] c0);
    n_cmp++;
    if (o_stock !== {c2, c1, c0}) begin
      n_bad++;
      $display("FAIL %s stock got=%0d/%0d/%0d want=%0d/%0d/%0d", name,
               o_stock[23:16], o_stock[15:8], o_stock[7:0], c2, c1, c0);
    end
  endtask

  task automatic test_reset();
    reset = 1'b1; i_start = 1'b0; i_amount = '0; i_coin_ready = 1'b0; i_refill = '0;
    step(); step();
    n_cmp++;
    if ({o_return_coin, o_busy, o_done, o_remainder} !== '0) begin
      n_bad++;
      $display("FAIL reset_outputs got coin=%b busy=%b done=%b rem=%0d want all 0",
               o_return_coin, o_busy, o_done, o_remainder);
    end
    check_stock("reset", 8, 8, 8);
    #3 reset = 1'b0;
    step();
  endtask

  task automatic test_largest_first();
    logic [2:0] exp_c [3];
    exp_c = '{3'b100, 3'b010, 3'b001};
    pay(31'd1600);
    n_cmp++;
    if (timed_out || coin_log.size() != 3) begin
      n_bad++;
      $display("FAIL largest_count got=%0d want=3 timeout=%b", coin_log.size(), timed_out);
    end else begin
      for (int i = 0; i < 3; i++) begin
        n_cmp++;
        if (coin_log[i] !== exp_c[i]) begin
          n_bad++;
          $display("FAIL largest_coin%0d got=%b want=%b", i, coin_log[i], exp_c[i]);
        end
      end
    end
    n_cmp++;
    if (done_cyc != 7) begin
      n_bad++;
      $display("FAIL largest_done_cycle got=%0d want=7", done_cyc);
    end
    n_cmp++;
    if (got_rem !== 31'd0 || busy_after !== 1'b0) begin
      n_bad++;
      $display("FAIL largest_rem_busy got rem=%0d busy=%b want rem=0 busy=0", got_rem, busy_after);
    end
    check_stock("largest", 7, 7, 7);
  endtask

  task automatic test_zero_amount();
    pay(31'd0);
    n_cmp++;
    if (coin_log.size() != 0 || done_cyc != 1 || got_rem !== 31'd0) begin
      n_bad++;
      $display("FAIL zero_amount got coins=%0d done_cycle=%0d rem=%0d want 0/1/0",
               coin_log.size(), done_cyc, got_rem);
    end
    check_stock("zero", 7, 7, 7);
  endtask

  task automatic test_no_coin2();
    logic [2:0] exp_c [4];
    exp_c = '{3'b010, 3'b010, 3'b010, 3'b001};
    for (int i = 0; i < 7; i++) pay(31'd1000);
    check_stock("drain", 0, 7, 7);
    pay(31'd1600);
    n_cmp++;
    if (coin_log.size() != 4) begin
      n_bad++;
      $display("FAIL nocoin2_count got=%0d want=4", coin_log.size());
    end else begin
      for (int i = 0; i < 4; i++) begin
        n_cmp++;
        if (coin_log[i] !== exp_c[i]) begin
          n_bad++;
          $display("FAIL nocoin2_coin%0d got=%b want=%b", i, coin_log[i], exp_c[i]);
        end
      end
    end
    n_cmp++;
    if (got_rem !== 31'd0 || done_cyc != 9) begin
      n_bad++;
      $display("FAIL nocoin2_rem got rem=%0d cycle=%0d want rem=0 cycle=9", got_rem, done_cyc);
    end
    check_stock("nocoin2", 0, 4, 6);
  endtask

  task automatic test_remainder();
    pay(31'd250);
    n_cmp++;
    if (coin_log.size() != 2 || coin_log[0] !== 3'b001 || coin_log[1] !== 3'b001) begin
      n_bad++;
      $display("FAIL rem250_coins got count=%0d want two 001 coins", coin_log.size());
    end
    n_cmp++;
    if (got_rem !== 31'd50) begin
      n_bad++;
      $display("FAIL rem250_remainder got=%0d want=50", got_rem);
    end
    n_cmp++;
    if (o_remainder !== 31'd50) begin
      n_bad++;
      $display("FAIL rem250_hold got=%0d want=50", o_remainder);
    end
    check_stock("rem250", 0, 4, 4);
  endtask

  task automatic test_stall();
    int stable;
    int cyc;
    i_amount = 31'd500; i_coin_ready = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    stable = 0;
    for (int i = 0; i < 5; i++) begin
      if (o_return_coin === 3'b010) stable++;
      if (i == 4) i_coin_ready = 1'b1;
      if (i == 0) begin
        i_start = 1'b1; i_amount = 31'd100;  // must be ignored while busy
      end else begin
        i_start = 1'b0;
      end
      step();
    end
    $display("stall stable_cycles=%0d coin_after=%b stock1=%0d", stable, o_return_coin, o_stock[15:8]);
    n_cmp++;
    if (stable != 5) begin
      n_bad++;
      $display("FAIL stall_stable got=%0d want=5", stable);
    end
    check_stock("stall", 0, 3, 4);
    cyc = 0;
    while (!o_done && cyc < 20) begin step(); cyc++; end
    n_cmp++;
    if (!o_done || cyc != 1 || o_remainder !== 31'd0) begin
      n_bad++;
      $display("FAIL stall_done got done=%b cycles=%0d rem=%0d want 1/1/0", o_done, cyc, o_remainder);
    end
    step();
    n_cmp++;
    if (o_busy !== 1'b0 || o_return_coin !== 3'b000) begin
      n_bad++;
      $display("FAIL stall_ignored_start got busy=%b coin=%b want 0/000", o_busy, o_return_coin);
    end
    check_stock("stall_after", 0, 3, 4);
  endtask

  task automatic test_refill();
    int cyc;
    i_amount = 31'd500; i_coin_ready = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    i_coin_ready = 1'b1; i_refill = 3'b010;
    step();
    i_refill = 3'b000;
    $display("refill_collision coin=%b stock1=%0d", o_return_coin, o_stock[15:8]);
    check_stock("refill_collision", 0, 3, 4);
    cyc = 0;
    while (!o_done && cyc < 20) begin step(); cyc++; end
    n_cmp++;
    if (!o_done) begin
      n_bad++;
      $display("FAIL refill_collision_done got done=0 want=1");
    end
    step();
    for (int i = 0; i < 252; i++) begin
      i_refill = 3'b011;
      step();
    end
    i_refill = 3'b000;
    check_stock("refill_to_255", 0, 255, 255);
    i_refill = 3'b010;
    step();
    i_refill = 3'b000;
    $display("refill_saturate stock1=%0d", o_stock[15:8]);
    check_stock("refill_saturate", 0, 255, 255);
  endtask

  task automatic test_reset_mid();
    int dones;
    i_amount = 31'd1000; i_coin_ready = 1'b0; i_start = 1'b1;
    step();
    i_start = 1'b0;
    step();
    n_cmp++;
    if (o_return_coin !== 3'b010 || o_busy !== 1'b1) begin
      n_bad++;
      $display("FAIL resetmid_dispense got coin=%b busy=%b want 010/1", o_return_coin, o_busy);
    end
    #2 reset = 1'b1;
    #1;
    $display("reset_mid coin=%b busy=%b done=%b stock=%0d/%0d/%0d", o_return_coin, o_busy,
             o_done, o_stock[23:16], o_stock[15:8], o_stock[7:0]);
    n_cmp++;
    if ({o_return_coin, o_busy, o_done, o_remainder} !== '0) begin
      n_bad++;
      $display("FAIL resetmid_outputs got coin=%b busy=%b done=%b rem=%0d want all 0",
               o_return_coin, o_busy, o_done, o_remainder);
    end
    check_stock("resetmid", 8, 8, 8);
    dones = 0;
    i_coin_ready = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_done) dones++;
    end
    reset = 1'b0;
    for (int i = 0; i < 3; i++) begin
      step();
      if (o_done || o_busy) dones++;
    end
    n_cmp++;
    if (dones != 0) begin
      n_bad++;
      $display("FAIL resetmid_no_done got=%0d want=0", dones);
    end
  endtask

  task automatic test_back_to_back();
    pay(31'd1600);
    n_cmp++;
    if (coin_log.size() != 3 || done_cyc != 7 || got_rem !== 31'd0) begin
      n_bad++;
      $display("FAIL after_reset got coins=%0d cycle=%0d rem=%0d want 3/7/0",
               coin_log.size(), done_cyc, got_rem);
    end
    check_stock("after_reset", 7, 7, 7);
    pay(31'd100);
    n_cmp++;
    if (coin_log.size() != 1 || coin_log[0] !== 3'b001 || done_cyc != 3) begin
      n_bad++;
      $display("FAIL back_to_back got coins=%0d cycle=%0d want 1 coin 001 cycle 3",
               coin_log.size(), done_cyc);
    end
    check_stock("back_to_back", 7, 7, 6);
  endtask

  initial begin
    test_reset();
    test_largest_first();
    test_zero_amount();
    test_no_coin2();
    test_remainder();
    test_stall();
    test_refill();
    test_reset_mid();
    test_back_to_back();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule

// File: doc/change_dispenser.md
# change_dispenser

Sequential coin-return engine on the output side of the vending machine. On a return request it takes the customer balance and pays it out as a sequence of one-hot coin pulses toward the coin hopper, largest denomination first, within per-denomination stock limits. It reports any balance it cannot pay. It is the paying end of the `o_return_coin` path whose values the state calculator subtracts from `current_total`.

## Interface
- `kNumCoins`, default 3: number of denominations; coin k is bit k of every coin vector.
- `kTotalBits`, default 31: width of amounts.
- `kCoinValue0` / `kCoinValue1` / `kCoinValue2`, defaults 100 / 500 / 1000: denomination values, strictly ascending.
- `kInitStock`, default 8: reset value of every stock counter.
- `clk`  in  1: clock, rising edge.
- `reset`  in  1: asynchronous, active-high reset.
- `i_start`  in  1: one-cycle request to pay `i_amount`; honoured only in IDLE.
- `i_amount`  in  `kTotalBits`: balance to return, sampled with `i_start`.
- `i_coin_ready`  in  1: hopper accepted the coin shown on `o_return_coin` at this edge.
- `i_refill`  in  `kNumCoins`: one-cycle pulse per bit; adds one coin to that stock.
- `o_return_coin`  out  `kNumCoins`: one-hot coin being paid (registered); zero when not dispensing.
- `o_busy`  out  1: high in every state except IDLE.
- `o_done`  out  1: one-cycle pulse at the end of a request.
- `o_remainder`  out  `kTotalBits`: unpaid balance, valid while `o_done` is high and held until the next `i_start`.
- `o_stock`  out  `8*kNumCoins`: stock counters, coin k at bits [8k+7:8k].

## Operation
- States: IDLE, SELECT, DISPENSE, DONE.
- IDLE + `i_start`:
  - latch `i_amount` into `remaining`;
  - go to SELECT;
  - clear `o_remainder`.
- SELECT:
  - pick the highest k with `kCoinValuek <= remaining` and stock k > 0;
  - if found, register `o_return_coin = 1<<k` and go to DISPENSE;
  - otherwise go to DONE.
- DISPENSE: hold `o_return_coin` stable until an edge where `i_coin_ready` = 1. At that edge:
  - `remaining -= kCoinValuek`;
  - stock k decrements;
  - `o_return_coin` clears;
  - go to SELECT.
- DONE:
  - `o_done` = 1 for this cycle;
  - `o_remainder = remaining`;
  - next state is IDLE.
- Arithmetic:
  - `remaining` is `kTotalBits` unsigned;
  - it is never decremented below zero, because a coin is only selected when its value is ≤ `remaining`;
  - comparisons are unsigned.
- Stock counters are 8-bit:
  - refill saturates at 255;
  - a refill and an accepted coin on the same edge and same denomination leave the count unchanged;
  - refill is accepted in any state.
- `i_start` outside IDLE is ignored; no queuing.
- `i_amount` = 0 passes IDLE → SELECT → DONE with `o_remainder` = 0 and no coins.
- `i_coin_ready` outside DISPENSE is ignored.
- Reset value of every output and register:
  - `o_return_coin` = 0, `o_busy` = 0, `o_done` = 0, `o_remainder` = 0;
  - every stock counter = `kInitStock`;
  - state = IDLE.
- Reset mid-request:
  - the request is dropped immediately, with no `o_done`;
  - the balance is not paid;
  - stock reverts to `kInitStock`.

## Timing
- `i_start` sampled at edge N:
  - `o_busy` is high after N;
  - SELECT occupies cycle N+1;
  - the first coin is visible after edge N+1.
- With `i_coin_ready` held high, each coin costs 2 cycles (DISPENSE then SELECT). A request of c coins completes with `o_done` in cycle N + 2c + 1 after edge N; `o_busy` drops the cycle after `o_done`.
- Each cycle of hopper stall (`i_coin_ready` = 0) extends DISPENSE by one cycle.
- `o_return_coin` is held bit-stable throughout the stall.
- The earliest new `i_start` is accepted at the edge ending the cycle after `o_done`.
- `o_stock` reflects a decrement or refill the cycle after the edge on which it occurs.

## Test plan
- Stock 8/8/8, start with amount 1600, ready tied high:
  - coins are one-hot 100, 010, 001 (1000, 500, 100) in that order;
  - `o_done` at N+7 with `o_remainder` = 0;
  - stock reads 7/7/7.
- Stock of coin2 = 0, amount 1600:
  - coins are 500, 500, 500, 100;
  - `o_remainder` = 0;
  - coin1 stock drops by 3.
- Amount 250:
  - coins are 100, 100;
  - `o_remainder` = 50.
- Stall: amount 500 with `i_coin_ready` low for 4 cycles in DISPENSE:
  - `o_return_coin` = 010 stays stable for 5 cycles;
  - a single decrement occurs;
  - `o_done` follows.
- `i_refill` = 010 on the same edge coin1 is accepted: coin1 stock is unchanged. Refill at 255 stays 255.
- Assert `reset` during DISPENSE of a 1000 request:
  - all outputs are 0 immediately;
  - no `o_done`;
  - stock = `kInitStock`;
  - a new start after reset behaves normally.
